lbp_core: RTL

//  Local Binary Pattern engine for a 128x128 8-bit grayscale image.
//  - Reads pixels from the external gray memory over a req/addr/data interface.
//  - Computes the 8-bit LBP code of every interior pixel.
//  - Writes each code to the external LBP memory; raises finish when the image is done.
//  - Sits between the gray-image memory (upstream) and the LBP result memory (downstream).

---
 rtl/lbp_if.sv | 15 +
 rtl/lbp_core.sv | 137 +++++++++++++
 2 files changed

// File: rtl/lbp_if.sv
// lbp_if: gray-memory read port and LBP-memory write port of lbp_core
interface lbp_if #(parameter int ADDR_W = 14);
   logic              gray_ready;
   logic              gray_req;
   logic [ADDR_W-1:0] gray_addr;
   logic [7:0]        gray_data;
   logic              lbp_valid;
   logic [ADDR_W-1:0] lbp_addr;
   logic [7:0]        lbp_data;
   logic              finish;
   modport master(input gray_ready, gray_data,
                  output gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish);
   modport slave(output gray_ready, gray_data,
                 input gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish);
endinterface

// File: rtl/lbp_core.sv
// lbp_core: 3x3 LBP engine over an IMG_W x IMG_H image; LBP_BORDER_WRITE_EN adds zero writes to the border
module lbp_core #(
   parameter int IMG_W  = 128,
   parameter int IMG_H  = 128,
   parameter int ADDR_W = 14
) (
   input logic    clk,
   input logic    reset,
   lbp_if.master  bus
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FILL  = 3'd1;
   localparam logic [2:0] S_SHIFT = 3'd2;
   localparam logic [2:0] S_LAST  = 3'd3;
   localparam logic [2:0] S_WRITE = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;
   localparam logic [6:0] COL_MAX = 7'(IMG_W - 2);
   localparam logic [6:0] ROW_MAX = 7'(IMG_H - 2);
   logic [2:0]        r_state;
   logic [6:0]        r_row, r_col, r_fcol;
   logic [1:0]        r_ro, r_cro;
   logic [7:0]        r_w [3][3];
   logic              r_req, r_lv, r_fin;
   logic [ADDR_W-1:0] r_gaddr, r_laddr;
   logic [7:0]        r_ldata;
   logic [ADDR_W-1:0] w_gaddr, w_laddr;
   logic [7:0]        w_c, w_code;
   logic              w_last;
   assign w_gaddr = ADDR_W'(IMG_W) * (ADDR_W'(r_row) + ADDR_W'(r_ro) - ADDR_W'(1)) + ADDR_W'(r_fcol);
   assign w_laddr = ADDR_W'(IMG_W) * ADDR_W'(r_row) + ADDR_W'(r_col);
   assign w_last  = (r_ro == 2'd2) && (r_fcol == r_col + 7'd1);
   assign w_c     = r_w[1][1];
   assign w_code  = {r_w[2][2] >= w_c, r_w[2][1] >= w_c, r_w[2][0] >= w_c, r_w[1][2] >= w_c,
                     r_w[1][0] >= w_c, r_w[0][2] >= w_c, r_w[0][1] >= w_c, r_w[0][0] >= w_c};
   assign bus.gray_req  = r_req;
   assign bus.gray_addr = r_gaddr;
   assign bus.lbp_valid = r_lv;
   assign bus.lbp_addr  = r_laddr;
   assign bus.lbp_data  = r_ldata;
   assign bus.finish    = r_fin;
`ifdef LBP_BORDER_WRITE_EN
   localparam logic [2:0]        S_BORDER = 3'd6;
   localparam logic [ADDR_W-1:0] B_LO  = ADDR_W'(IMG_W);
   localparam logic [ADDR_W-1:0] B_HI  = ADDR_W'(IMG_W * (IMG_H - 1));
   localparam logic [ADDR_W-1:0] A_END = ADDR_W'(IMG_W * IMG_H - 1);
   logic [ADDR_W-1:0] r_baddr, w_bstep;
   // from the left border pixel of a middle row jump straight to its right border pixel
   assign w_bstep = (r_baddr >= B_LO && r_baddr < B_HI && (r_baddr & ADDR_W'(IMG_W - 1)) == '0)
                    ? ADDR_W'(IMG_W - 1) : ADDR_W'(1);
`endif
   // capture the datum requested last cycle; a top-row datum starts a new column, so shift left first
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
               r_w[i][j] <= '0;
      end else if (r_req) begin
         if (r_cro == 2'd0)
            for (int i = 0; i < 3; i++) begin
               r_w[i][0] <= r_w[i][1];
               r_w[i][1] <= r_w[i][2];
            end
         r_w[r_cro][2] <= bus.gray_data;
      end
   end
   // fetch/write sequencer: column-wise fetch, one write per centre pixel, then finish
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_row   <= 7'd1;
         r_col   <= 7'd1;
         r_fcol  <= '0;
         r_ro    <= '0;
         r_cro   <= '0;
         r_req   <= 1'b0;
         r_lv    <= 1'b0;
         r_fin   <= 1'b0;
         r_gaddr <= '0;
         r_laddr <= '0;
         r_ldata <= '0;
`ifdef LBP_BORDER_WRITE_EN
         r_baddr <= '0;
`endif
      end else begin
         r_req <= 1'b0;
         r_lv  <= 1'b0;
         case (r_state)
            S_IDLE: if (bus.gray_ready) r_state <= S_FILL;
            S_FILL, S_SHIFT: begin
               r_req   <= 1'b1;
               r_gaddr <= w_gaddr;
               r_cro   <= r_ro;
               r_ro    <= (r_ro == 2'd2) ? 2'd0 : r_ro + 2'd1;
               r_fcol  <= (r_ro == 2'd2) ? r_fcol + 7'd1 : r_fcol;
               if (w_last) r_state <= S_LAST;
            end
            S_LAST: r_state <= S_WRITE;
            S_WRITE: begin
               r_lv    <= 1'b1;
               r_laddr <= w_laddr;
               r_ldata <= w_code;
               if (r_col < COL_MAX) begin
                  r_col   <= r_col + 7'd1;
                  r_fcol  <= r_col + 7'd2;
                  r_state <= S_SHIFT;
               end else if (r_row < ROW_MAX) begin
                  r_row   <= r_row + 7'd1;
                  r_col   <= 7'd1;
                  r_fcol  <= '0;
                  r_state <= S_FILL;
               end else begin
`ifdef LBP_BORDER_WRITE_EN
                  r_baddr <= '0;
                  r_state <= S_BORDER;
`else
                  r_fin   <= 1'b1;
                  r_state <= S_DONE;
`endif
               end
            end
`ifdef LBP_BORDER_WRITE_EN
            S_BORDER: begin
               r_lv    <= 1'b1;
               r_laddr <= r_baddr;
               r_ldata <= '0;
               r_baddr <= r_baddr + w_bstep;
               if (r_baddr == A_END) begin
                  r_fin   <= 1'b1;
                  r_state <= S_DONE;
               end
            end
`endif
            default: ;
         endcase
      end
   end
endmodule
